sym_seq_detector: RTL
=====================

Name: sym_seq_detector

Overview:
- Parametrised successor to the team's two-input behavioural sequential circuit: the {a,b} pair becomes a SYM_W-bit symbol stream.
- Detects a runtime-programmable sequence of DEPTH symbols and emits a one-cycle match pulse.
- Keeps a saturating match counter.
- Selectable overlapping / non-overlapping detection.
- Sits between a stimulus/decoder front end and status logic. Single clock domain.

Parameters:
- SYM_W, 2, bits per input symbol (2 = the legacy {a,b} pair)
- DEPTH, 4, pattern length in symbols, >= 2
- CNT_W, 8, match counter width, >= 1

Ports:
- clk  in  1  clock, all state updates on rising edge
- res  in  1  reset, asynchronous, active-low (res=0 resets)
- clr  in  1  synchronous clear of history, fill, counter, flags
- in_valid  in  1  symbol on sym is accepted this edge when 1
- sym  in  SYM_W  input symbol
- pattern  in  DEPTH*SYM_W  target sequence. First symbol in the MSB slice, last symbol in the LSB slice. Must be stable while detecting.
- overlap  in  1  1 = overlapping matches allowed, 0 = restart after each match
- y  out  1  match pulse, one clock wide
- fill  out  $clog2(DEPTH+1)  number of valid symbols in history, 0..DEPTH
- match_cnt  out  CNT_W  matches since reset/clr, saturating
- cnt_sat  out  1  sticky: match_cnt has saturated

Behaviour:
- Reset (res=0, asynchronous, any time, including mid-sequence):
  - history=0, fill=0, y=0, match_cnt=0, cnt_sat=0 immediately.
  - Release is sampled at the next rising edge.
- History: DEPTH*SYM_W shift register. On an accepted symbol: hist_next = {hist[(DEPTH-1)*SYM_W-1:0], sym}. The newest symbol is in the LSB slice.
- Fill FSM (state encoded by fill):
  - EMPTY (fill=0)
  - FILLING (0<fill<DEPTH)
  - ARMED (fill=DEPTH)
  - Each accepted symbol increments fill, saturating at DEPTH. No change when in_valid=0.
- Match condition, evaluated on each accepted symbol: (fill_next==DEPTH) and (hist_next==pattern).
  - Comparison uses hist_next, so the completing symbol counts.
- On match:
  - y=1 for exactly the cycle following the accepting edge (registered output), otherwise 0.
  - match_cnt increments at the same edge.
  - If match_cnt is all-ones, it holds and cnt_sat is set.
  - cnt_sat stays 1 until res or clr.
- overlap=1: history and fill are kept after a match, so later symbols can complete overlapping matches.
- overlap=0: on the match edge, fill is forced to 0 and history cleared to 0. The next DEPTH accepted symbols must refill before another match can occur.
- in_valid=0 cycles:
  - History, fill and counter hold.
  - y=0 in the following cycle.
  - Gaps never break a partial sequence.
- clr=1 at an edge:
  - Same values as reset, synchronously.
  - Has priority over a simultaneous accepted symbol: that symbol is discarded and no match or y is produced.
- pattern/overlap changes take effect on the next accepted symbol. No pipeline is flushed.
- Latency: completing symbol sampled at edge k, so y=1 and the updated match_cnt are visible from edge k until edge k+1.
- No combinational path from inputs to outputs.

Test Plan:
All cases use SYM_W=2, DEPTH=4, CNT_W=8 unless stated.
- Async reset: feed 1,2,3 (fill=3), drop res mid-cycle → fill=0, y=0, match_cnt=0 before the next edge. Release, then feed 1,2,3,0 with pattern 8'b01_10_11_00 → match requires all 4 symbols again.
- Basic match: pattern 8'b01_10_11_00, in_valid=1 each cycle, sym 1,2,3,0 → y=1 for exactly one cycle after the 4th edge, match_cnt=1, fill=4. The prefix 1,2,3 alone never asserts y.
- Overlap mode: pattern 8'b01_01_01_01, six consecutive sym=1:
  - overlap=1 → 3 y pulses on symbols 4,5,6, match_cnt=3.
  - overlap=0 (fresh run) → 1 pulse, match_cnt=1, fill=2 at end.
- Idle gaps: basic pattern with in_valid=0 for 3 cycles between each symbol → single y pulse after the 4th accepted symbol. y=0 and fill unchanged during gaps.
- Saturation (CNT_W=2): 5 matches in overlap=0 mode → match_cnt=3 and cnt_sat=1 after the 4th match, unchanged by the 5th. Then clr=1 for one edge → match_cnt=0, cnt_sat=0, fill=0.
- clr vs completing symbol: after 1,2,3, assert clr together with sym=0, in_valid=1 → y stays 0, match_cnt=0, fill=0.

Source files
------------

// File: rtl/sym_seq_detector.sv
// Programmable DEPTH-symbol sequence detector with registered match pulse,
// saturating match counter and selectable overlapping/non-overlapping detection.
module sym_seq_detector #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [SYM_W-1:0]           sym,
    input  logic [DEPTH*SYM_W-1:0]     pattern,
    input  logic                       overlap,
    output logic                       y,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int HIST_W = DEPTH * SYM_W;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } fill_state_e;

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              y_q, y_d;
    logic              sat_q, sat_d;

    fill_state_e       state;
    logic [HIST_W-1:0] hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    // The fill count is the FSM state register; decode it into named states.
    always_comb begin
        if (fill_q == '0) begin
            state = EMPTY;
        end else if (fill_q >= FILL_FULL) begin
            state = ARMED;
        end else begin
            state = FILLING;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            sat_q  <= sat_d;
        end
    end

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        y_d        = 1'b0;
        sat_d      = sat_q;
        hist_shift = {hist_q[HIST_W-SYM_W-1:0], sym};
        match      = 1'b0;

        case (state)
            EMPTY, FILLING: fill_inc = fill_q + FILL_W'(1);
            ARMED:          fill_inc = fill_q;
            default:        fill_inc = '0;
        endcase

        if (clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
        end else if (in_valid) begin
            // Compare against the post-shift history so the completing symbol counts.
            match  = (fill_inc == FILL_FULL) && (hist_shift == pattern);
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                y_d = 1'b1;
                if (cnt_q == '1) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!overlap) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end
    end

    assign y         = y_q;
    assign fill      = fill_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule
